spi_command_rx: RTL



---
 rtl/spi_command_rx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_command_rx.sv
// spi_command_rx: SPI mode-0 slave byte receiver feeding a command FIFO.
// Host bytes are deserialised MSB-first and pushed into a circular buffer.
// A status byte {overflow, full, empty, min(level,31)} is shifted back on MISO.
module spi_command_rx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          spi_sck,
    input  logic                          spi_cs_n,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    output logic [7:0]                    out_byte,
    output logic                          out_ready,
    input  logic                          next,
    input  logic                          flush,
    input  logic                          clear_overflow,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_hist_q;
    logic                   cs_hist_q;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_hist_q;
    assign sck_fall = ~sck_s & sck_hist_q;
    assign cs_fall  = ~cs_s & cs_hist_q;
    assign cs_rise  = cs_s & ~cs_hist_q;

    // Bring the SPI pins into the clk domain; cs_n idles high so it resets high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_hist_q  <= 1'b0;
            cs_hist_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_hist_q  <= sck_s;
            cs_hist_q   <= cs_s;
        end
    end

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;

    logic       full, empty;
    logic [4:0] lvl_sat;
    logic [7:0] status;

    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q == '0);

    // Level saturates at 31 so it always fits the 5-bit status field
    always_comb begin
        lvl_sat = 5'd31;
        if (32'(level_q) < 32'd31) lvl_sat = 5'(level_q);
    end

    assign status = {overflow_q, full, empty, lvl_sat};

    // ------------------------------------------------------------------
    // Frame / shift logic
    // ------------------------------------------------------------------
    logic [2:0] bit_ctr_q, bit_ctr_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_reg_q, tx_reg_d;
    logic       push;
    logic [7:0] push_byte;

    assign push_byte = {rx_shift_q[6:0], mosi_s};

    // Frame boundaries win over data edges; the eighth rising edge pushes
    // the completed byte and reloads the status byte for the host.
    always_comb begin
        bit_ctr_d  = bit_ctr_q;
        rx_shift_d = rx_shift_q;
        tx_reg_d   = tx_reg_q;
        push       = 1'b0;
        if (cs_fall) begin
            bit_ctr_d = '0;
            tx_reg_d  = status;
        end else if (cs_rise) begin
            // Partial byte is abandoned: only the counter matters, since
            // the next byte shifts a full eight bits through rx_shift.
            bit_ctr_d = '0;
        end else if (!cs_s) begin
            if (sck_rise) begin
                rx_shift_d = push_byte;
                if (bit_ctr_q == 3'd7) begin
                    push      = 1'b1;
                    bit_ctr_d = '0;
                    tx_reg_d  = status;
                end else begin
                    bit_ctr_d = bit_ctr_q + 3'd1;
                end
            end else if (sck_fall) begin
                tx_reg_d = {tx_reg_q[6:0], 1'b0};
            end
        end
    end

    // Shift/counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_ctr_q  <= '0;
            rx_shift_q <= '0;
            tx_reg_q   <= '0;
        end else begin
            bit_ctr_q  <= bit_ctr_d;
            rx_shift_q <= rx_shift_d;
            tx_reg_q   <= tx_reg_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic pop, push_ok, wr_en;

    // Flush beats push and pop; a full FIFO still accepts a push when a pop
    // frees a slot in the same cycle. Setting overflow beats clearing it.
    always_comb begin
        pop        = next & ~empty;
        push_ok    = push & (~full | pop);
        wr_en      = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (clear_overflow) overflow_d = 1'b0;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push && !push_ok) overflow_d = 1'b1;
            if (push_ok) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop)      level_d = level_q + 1'b1;
            else if (pop && !push_ok) level_d = level_q - 1'b1;
        end
    end

    // Pointer, level and sticky overflow registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage; cleared on reset so the head reads 0 out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_byte  = mem_q[rd_ptr_q];
    assign out_ready = ~empty;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign spi_miso  = ~cs_s & tx_reg_q[7];

endmodule
